// File: rtl/cv32e40p_fetch_realigner_if.sv
// Fetch-side and decoder-side handshake bundle for the realigner.
// master is the realigner itself, slave is its environment.
interface cv32e40p_fetch_realigner_if;
   logic        fetch_valid_i;
   logic        fetch_ready_o;
   logic [31:0] fetch_rdata_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_o;
   logic        instr_compressed_o;
   logic [31:0] pc_o;
   logic        branch_i;
   logic [31:0] branch_addr_i;

   modport master (
      input  fetch_valid_i,
      input  fetch_rdata_i,
      input  instr_ready_i,
      input  branch_i,
      input  branch_addr_i,
      output fetch_ready_o,
      output instr_valid_o,
      output instr_o,
      output instr_compressed_o,
      output pc_o
   );

   modport slave (
      output fetch_valid_i,
      output fetch_rdata_i,
      output instr_ready_i,
      output branch_i,
      output branch_addr_i,
      input  fetch_ready_o,
      input  instr_valid_o,
      input  instr_o,
      input  instr_compressed_o,
      input  pc_o
   );
endinterface

// File: rtl/cv32e40p_fetch_realigner.sv
// Realigns word fetches into one instruction per handshake,
// stitching straddling 32-bit instructions via a halfword residue.
module cv32e40p_fetch_realigner #(
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
   input logic clk,
   input logic rst,
   cv32e40p_fetch_realigner_if.master bus
);

   typedef enum logic [1:0] {
      ALIGNED,
      MISALIGNED,
      BR_SKIP
   } state_t;

   state_t      state_q;
   logic [15:0] resid_q;
   logic [31:0] pc_q;

   logic [31:0] w;
   logic        valid;
   logic        ready;
   logic [31:0] instr;
   logic        hs;
   logic        w_comp;
   logic        r_comp;
   logic [31:0] br_pc;
   logic [31:0] boot_pc;

   assign w       = bus.fetch_rdata_i;
   assign w_comp  = (w[1:0] != 2'b11);
   assign r_comp  = (resid_q[1:0] != 2'b11);
   assign br_pc   = bus.branch_addr_i & ~32'h1;
   assign boot_pc = BOOT_ADDR & ~32'h1;

   always_comb begin
      valid = 1'b0;
      ready = 1'b0;
      instr = 32'h0;
      unique case (state_q)
         ALIGNED: begin
            valid = bus.fetch_valid_i;
            ready = bus.instr_ready_i;
            instr = w_comp ? {16'h0, w[15:0]} : w;
         end
         MISALIGNED: begin
            if (r_comp) begin
               valid = 1'b1;
               instr = {16'h0, resid_q};
            end else begin
               valid = bus.fetch_valid_i;
               ready = bus.instr_ready_i;
               instr = {w[15:0], resid_q};
            end
         end
         BR_SKIP: begin
            ready = 1'b1;
         end
         default: ;
      endcase
      // A redirect or reset stalls both sides for this cycle
      if (rst || bus.branch_i) begin
         valid = 1'b0;
         ready = 1'b0;
      end
   end

   assign hs                     = valid && bus.instr_ready_i;
   assign bus.instr_valid_o      = valid;
   assign bus.fetch_ready_o      = ready;
   assign bus.instr_o            = instr;
   assign bus.instr_compressed_o = valid && (instr[1:0] != 2'b11);
   assign bus.pc_o               = pc_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= BOOT_ADDR[1] ? BR_SKIP : ALIGNED;
         pc_q    <= boot_pc;
         resid_q <= 16'h0;
      end else if (bus.branch_i) begin
         state_q <= bus.branch_addr_i[1] ? BR_SKIP : ALIGNED;
         pc_q    <= br_pc;
         resid_q <= 16'h0;
      end else begin
         unique case (state_q)
            ALIGNED: begin
               if (hs && w_comp) begin
                  resid_q <= w[31:16];
                  pc_q    <= pc_q + 32'd2;
                  state_q <= MISALIGNED;
               end else if (hs) begin
                  pc_q    <= pc_q + 32'd4;
               end
            end
            MISALIGNED: begin
               if (hs && r_comp) begin
                  pc_q    <= pc_q + 32'd2;
                  state_q <= ALIGNED;
               end else if (hs) begin
                  resid_q <= w[31:16];
                  pc_q    <= pc_q + 32'd4;
               end
            end
            BR_SKIP: begin
               // Low halfword precedes the target; keep only the upper one
               if (bus.fetch_valid_i) begin
                  resid_q <= w[31:16];
                  state_q <= MISALIGNED;
               end
            end
            default: state_q <= ALIGNED;
         endcase
      end
   end

endmodule

// File: tb/tb_cv32e40p_fetch_realigner.sv
// Table-driven bench for the fetch realigner with an
// instruction/pc scoreboard popped on every decoder handshake.
module tb_cv32e40p_fetch_realigner;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cv32e40p_fetch_realigner_if bus ();

   cv32e40p_fetch_realigner #(
      .BOOT_ADDR(32'h0000_0080)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic        r;
      logic        b;
      logic [31:0] ba;
      logic        fv;
      logic [31:0] w;
      logic        rdy;
      logic        eiv;
      logic        efr;
      logic [31:0] ei;
      logic [31:0] epc;
   } vec_t;

   typedef struct {
      logic [31:0] i;
      logic [31:0] pc;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   function automatic vec_t mk(
      input logic r, input logic b, input logic [31:0] ba,
      input logic fv, input logic [31:0] w, input logic rdy,
      input logic eiv, input logic efr,
      input logic [31:0] ei, input logic [31:0] epc);
      vec_t v;
      v.r = r; v.b = b; v.ba = ba; v.fv = fv; v.w = w;
      v.rdy = rdy; v.eiv = eiv; v.efr = efr; v.ei = ei; v.epc = epc;
      return v;
   endfunction

   initial begin
      exp_t e;
      string s;
      // reset, then aligned 32-bit stream
      tbl.push_back(mk(1,0,0, 1,32'h0000_0013,1, 0,0,0,0));
      tbl.push_back(mk(0,0,0, 1,32'h0000_0013,1, 1,1,32'h0000_0013,32'h80));
      tbl.push_back(mk(0,0,0, 1,32'h0040_0093,1, 1,1,32'h0040_0093,32'h84));
      // two compressed in one word
      tbl.push_back(mk(0,0,0, 1,32'h4505_0001,1, 1,1,32'h0000_0001,32'h88));
      tbl.push_back(mk(0,0,0, 0,32'h0,1,         1,0,32'h0000_4505,32'h8a));
      // straddling 32-bit, then compressed residue 0x1234
      tbl.push_back(mk(0,0,0, 1,32'h0093_0001,1, 1,1,32'h0000_0001,32'h8c));
      tbl.push_back(mk(0,0,0, 1,32'h1234_0040,1, 1,1,32'h0040_0093,32'h8e));
      tbl.push_back(mk(0,0,0, 0,32'h0,1,         1,0,32'h0000_1234,32'h92));
      // backpressure for 3 cycles, then branch to misaligned target
      tbl.push_back(mk(0,0,0, 1,32'h0040_0093,0, 1,0,32'h0040_0093,32'h94));
      tbl.push_back(mk(0,0,0, 1,32'h0040_0093,0, 1,0,32'h0040_0093,32'h94));
      tbl.push_back(mk(0,0,0, 1,32'h0040_0093,0, 1,0,32'h0040_0093,32'h94));
      tbl.push_back(mk(0,1,32'h202, 1,32'h0040_0093,1, 0,0,0,32'h94));
      tbl.push_back(mk(0,0,0, 1,32'h0001_ABCD,1, 0,1,0,32'h202));
      tbl.push_back(mk(0,0,0, 0,32'h0,1,         1,0,32'h0000_0001,32'h202));
      // aligned branch with bit 0 set
      tbl.push_back(mk(0,1,32'h301, 1,32'h0000_0013,1, 0,0,0,32'h204));
      tbl.push_back(mk(0,0,0, 1,32'h0000_0013,1, 1,1,32'h0000_0013,32'h300));
      // wrap from 0xFFFF_FFFE
      tbl.push_back(mk(0,1,32'hFFFF_FFFE, 0,32'h0,1, 0,0,0,32'h304));
      tbl.push_back(mk(0,0,0, 1,32'h0001_0000,1, 0,1,0,32'hFFFF_FFFE));
      tbl.push_back(mk(0,0,0, 0,32'h0,1,         1,0,32'h0000_0001,32'hFFFF_FFFE));
      tbl.push_back(mk(0,0,0, 1,32'h0001_0001,1, 1,1,32'h0000_0001,32'h0));
      // reset while MISALIGNED holds a residue
      tbl.push_back(mk(1,0,0, 0,32'h0,1,         0,0,0,0));
      tbl.push_back(mk(0,0,0, 0,32'h0,1,         0,1,0,32'h80));
      tbl.push_back(mk(0,0,0, 1,32'hFFFF_FFFF,1, 1,1,32'hFFFF_FFFF,32'h80));
      // 32-bit residue waiting on fetch, stalled, then issued
      tbl.push_back(mk(0,0,0, 1,32'h0513_0001,1, 1,1,32'h0000_0001,32'h84));
      tbl.push_back(mk(0,0,0, 0,32'h0,1,         0,1,0,32'h86));
      tbl.push_back(mk(0,0,0, 1,32'h0000_0000,0, 1,0,32'h0000_0513,32'h86));
      tbl.push_back(mk(0,0,0, 1,32'h0000_0000,1, 1,1,32'h0000_0513,32'h86));
      tbl.push_back(mk(0,0,0, 0,32'h0,1,         1,0,32'h0000_0000,32'h8a));

      rst = 1'b1;
      bus.fetch_valid_i = 1'b0;
      bus.fetch_rdata_i = 32'h0;
      bus.instr_ready_i = 1'b0;
      bus.branch_i = 1'b0;
      bus.branch_addr_i = 32'h0;

      for (int k = 0; k < tbl.size(); k++) begin
         @(negedge clk);
         rst               = tbl[k].r;
         bus.branch_i      = tbl[k].b;
         bus.branch_addr_i = tbl[k].ba;
         bus.fetch_valid_i = tbl[k].fv;
         bus.fetch_rdata_i = tbl[k].w;
         bus.instr_ready_i = tbl[k].rdy;
         if (tbl[k].eiv && tbl[k].rdy) begin
            e.i  = tbl[k].ei;
            e.pc = tbl[k].epc;
            sb.push_back(e);
         end
         #3;
         s = $sformatf("v%0d", k);
         chk({s, ".instr_valid"}, {31'h0, bus.instr_valid_o},
             {31'h0, tbl[k].eiv});
         chk({s, ".fetch_ready"}, {31'h0, bus.fetch_ready_o},
             {31'h0, tbl[k].efr});
         chk({s, ".compressed"}, {31'h0, bus.instr_compressed_o},
             {31'h0, tbl[k].eiv && (tbl[k].ei[1:0] != 2'b11)});
         if (!tbl[k].r)
            chk({s, ".pc"}, bus.pc_o, tbl[k].epc);
         if (tbl[k].eiv && !tbl[k].rdy)
            chk({s, ".stall_instr"}, bus.instr_o, tbl[k].ei);
         if (bus.instr_valid_o && bus.instr_ready_i) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL %s.unexpected_hs: got instr %h expected none",
                        s, bus.instr_o);
            end else begin
               e = sb.pop_front();
               chk({s, ".sb_instr"}, bus.instr_o, e.i);
               chk({s, ".sb_pc"}, bus.pc_o, e.pc);
            end
         end
      end

      chk("sb_leftover", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cv32e40p_fetch_realigner.md
# cv32e40p_fetch_realigner

Instruction realigner between the prefetch buffer and `cv32e40p_compressed_decoder`. It takes word-aligned 32-bit fetch words and produces one instruction per handshake on `instr_o`, which feeds the decoder's `instr_i`. It tracks the halfword PC, stitches 32-bit instructions that straddle a word boundary, and emits compressed instructions zero-extended. A 16-bit residue register allows a buffered compressed instruction to issue without a new fetch.

## Interface
- `BOOT_ADDR`, default `32'h0000_0080`: PC after reset; must be halfword aligned.
- `clk` input 1: the single clock.
- `rst` input 1: synchronous, active-high reset.
- `fetch_valid_i` input 1: `fetch_rdata_i` holds a valid word.
- `fetch_ready_o` output 1: the word is consumed this cycle when `fetch_valid_i && fetch_ready_o`.
- `fetch_rdata_i` input 32: fetch word; bits [15:0] are the lower halfword address.
- `instr_valid_o` output 1: `instr_o` is valid.
- `instr_ready_i` input 1: downstream accepts; the handshake is `instr_valid_o && instr_ready_i`.
- `instr_o` output 32: instruction to the compressed decoder; a compressed instruction is `{16'h0, c}`.
- `instr_compressed_o` output 1: `instr_o[1:0] != 2'b11`, qualified by `instr_valid_o`.
- `pc_o` output 32: address of `instr_o`.
- `branch_i` input 1: single-cycle redirect pulse.
- `branch_addr_i` input 32: redirect target; bit 0 is ignored.

## Operation
- **State.** FSM `{ALIGNED, MISALIGNED, BR_SKIP}`, plus `resid_q[15:0]` and `pc_q[31:0]`.
- **Outputs.** `instr_o`, `instr_valid_o` and `fetch_ready_o` are combinational from the state, `resid_q`, the fetch inputs and `instr_ready_i`. `pc_o = pc_q`.
- **ALIGNED** (`pc_q[1]=0`, no residue). Let W be `fetch_rdata_i`; `instr_valid_o = fetch_valid_i`.
  - `W[1:0]!=11`: `instr_o={16'h0,W[15:0]}`, `fetch_ready_o=instr_ready_i`. On handshake: `resid_q<=W[31:16]`, `pc_q+=2`, go to MISALIGNED.
  - `W[1:0]==11`: `instr_o=W`, `fetch_ready_o=instr_ready_i`. On handshake: `pc_q+=4`, stay in ALIGNED.
- **MISALIGNED** (`pc_q[1]=1`; `resid_q` is the halfword at `pc_q`).
  - `resid_q[1:0]!=11`: `instr_valid_o=1`, `instr_o={16'h0,resid_q}`, `fetch_ready_o=0`. On handshake: `pc_q+=2`, go to ALIGNED.
  - `resid_q[1:0]==11`: `instr_valid_o=fetch_valid_i`, `instr_o={W[15:0],resid_q}`, `fetch_ready_o=instr_ready_i`. On handshake: `resid_q<=W[31:16]`, `pc_q+=4`, stay in MISALIGNED.
- **BR_SKIP** (branch target had `addr[1]=1`).
  - `instr_valid_o=0`, `fetch_ready_o=1`.
  - On a fetch: discard `W[15:0]`, `resid_q<=W[31:16]`, go to MISALIGNED. `pc_q` is unchanged (already the target).
- **Branch** (highest priority after reset).
  - In the cycle `branch_i=1`, `instr_valid_o=0` and `fetch_ready_o=0`. No handshake completes and any fetch word present is not consumed.
  - Next state: `pc_q<={branch_addr_i[31:1],1'b0}`, residue dropped. State becomes ALIGNED if `branch_addr_i[1]==0`, else BR_SKIP.
  - The prefetcher flushes on the same pulse.
- **PC arithmetic.** 32-bit, modulo 2^32; wrap from `32'hFFFF_FFFE` to `0` is legal.
- **Backpressure.** While `instr_valid_o && !instr_ready_i`:
  - `instr_o` and `pc_o` stay stable as long as the fetch inputs stay stable.
  - No state changes, and no fetch is consumed.
- The decoder's `illegal_instr_o` is not observed by this block.

## Timing
- **Reset.** While `rst=1`: `instr_valid_o=0`, `fetch_ready_o=0`. Next cycle: state ALIGNED, `pc_q=BOOT_ADDR` (BR_SKIP if `BOOT_ADDR[1]=1`), `resid_q=16'h0`.
- **Latency.** 0 cycles, fetch word to `instr_o`, in ALIGNED and in MISALIGNED with a 32-bit residue. A compressed residue issues with no fetch input at all.
- **Throughput.** One instruction per cycle when `instr_ready_i=1` and the fetch supply keeps up. Two compressed halves of one word take 2 cycles but only 1 fetch.
- **Branch.**
  - Aligned target: 1 bubble cycle, the branch cycle itself.
  - Misaligned target: 1 bubble plus 1 BR_SKIP fetch cycle before the first instruction.
- **Simultaneous events.** `branch_i` with a pending handshake: the branch wins and the handshake does not occur. `rst` overrides `branch_i`.
- **Registers.** All updates occur on the rising edge of `clk`. Reset is synchronous.

## Test plan
- **Reset and aligned 32-bit stream.** Reset, then words `32'h0000_0013`, `32'h0040_0093` (32-bit) with `instr_ready_i=1` -> `pc_o` 0x80, then 0x84; `instr_compressed_o=0`; 1 instruction per cycle.
- **Two compressed in one word.** Word `32'h4505_0001` at 0x80 -> `instr_o=32'h0000_0001` at pc 0x80, then `32'h0000_4505` at 0x82. `fetch_ready_o=0` in the second cycle.
- **Straddling 32-bit.** Words `32'h0093_0001`, then `32'h1234_0040` -> c.nop at 0x80, then `instr_o=32'h0040_0093` at 0x82, then `resid_q=16'h1234` and `pc_o=0x86`.
- **Misaligned branch.** `branch_i` with target `32'h0000_0202`, then fetch of word 0x200 = `32'h0001_ABCD` -> one bubble, BR_SKIP consumes the word with no output, then `instr_o=32'h0000_0001` at 0x202.
- **Backpressure and branch priority.** Hold `instr_ready_i=0` for 3 cycles -> `instr_o`/`pc_o` stable, no fetch consumed. Assert `branch_i` during the stall -> no handshake, and `pc_o` equals the target in the following cycle.
- **Wrap and reset mid-stream.** Branch to `32'hFFFF_FFFE` with compressed `16'h0001` -> next `pc_o=0`. Assert `rst` while MISALIGNED holds a residue -> `pc_o=BOOT_ADDR`, residue discarded.
